// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit instruction
// words and writes them to consecutive imem word addresses starting at
// BASE_ADDR, holding the core in reset while a load is in progress.
//
// Optional build macro: LOADER_OPCODE_CHECK_EN
//   When defined, each assembled word's opcode field (bits [6:0]) is checked
//   against the supported set; an unsupported opcode aborts the load with
//   error set and the offending word is not written.
//   When undefined, every assembled word is written unchanged.
module imem_loader #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Largest legal word count: the full imem capacity, 2^ADDR_W.
    localparam logic [ADDR_W:0] CAP_LEN = {1'b1, {ADDR_W{1'b0}}};

`ifdef LOADER_OPCODE_CHECK_EN
    // True when the opcode field belongs to the supported instruction classes
    // (load, store, OP, OP-IMM, branch).
    function automatic logic opcode_supported(input logic [6:0] op);
        logic ok;
        case (op)
            7'b0000011,
            7'b0100011,
            7'b0110011,
            7'b0010011,
            7'b1100011: ok = 1'b1;
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction
`endif

    // State and datapath registers
    logic [1:0]        state_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]        byte_idx_r;
    logic [23:0]       word_r;
    logic [31:0]       wdata_r;
    logic              we_r;
    logic              busy_r;
    logic              hold_r;
    logic              done_r;
    logic              error_r;

    // Combinational decode
    logic [1:0]        state_nxt_s;
    logic              len_zero_s;
    logic              len_over_s;
    logic              start_acc_s;
    logic              load_go_s;
    logic              start_zero_s;
    logic              start_bad_s;
    logic              byte_ready_s;
    logic              xfer_s;
    logic              last_byte_s;
    logic [31:0]       full_word_s;
    logic              opcode_bad_s;
    logic [ADDR_W:0]   count_inc_s;
    logic              last_word_s;
    logic              abort_err_s;

    // Decode start requests, byte handshake and end-of-word/end-of-load events.
    always_comb begin
        len_zero_s   = (len == {(ADDR_W+1){1'b0}});
        len_over_s   = (len > CAP_LEN);
        start_acc_s  = (state_r == ST_IDLE) && start && !abort;
        load_go_s    = start_acc_s && !len_zero_s && !len_over_s;
        start_zero_s = start_acc_s && len_zero_s;
        start_bad_s  = start_acc_s && len_over_s;
        // A byte offered in an abort cycle is refused.
        byte_ready_s = (state_r == ST_RECV) && !abort;
        xfer_s       = byte_valid && byte_ready_s;
        last_byte_s  = xfer_s && (byte_idx_r == 2'd3);
        full_word_s  = {byte_data, word_r};
        count_inc_s  = count_r + {{ADDR_W{1'b0}}, 1'b1};
        last_word_s  = (count_inc_s == len_r);
        abort_err_s  = abort && (state_r != ST_IDLE);
`ifdef LOADER_OPCODE_CHECK_EN
        if (last_byte_s) begin
            opcode_bad_s = !opcode_supported(full_word_s[6:0]);
        end else begin
            opcode_bad_s = 1'b0;
        end
`else
        opcode_bad_s = 1'b0;
`endif
    end

    // Next-state logic; abort returns to IDLE from any active state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_go_s) begin
                    state_nxt_s = ST_RECV;
                end else if (start_zero_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_byte_s) begin
                    if (opcode_bad_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WRITE;
                    end
                end else begin
                    state_nxt_s = ST_RECV;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_word_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RECV;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered status/strobe outputs derived from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            hold_r <= 1'b0;
            done_r <= 1'b0;
            we_r   <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            hold_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_DONE);
            we_r   <= (state_nxt_s == ST_WRITE);
        end
    end

    // Sticky error flag: cleared by an accepted start, set by a bad length,
    // an abort of an active load or an unsupported opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_r <= 1'b0;
        end else if (load_go_s || start_zero_s) begin
            error_r <= 1'b0;
        end else if (start_bad_s || abort_err_s || opcode_bad_s) begin
            error_r <= 1'b1;
        end else begin
            error_r <= error_r;
        end
    end

    // Load context: word count target, words written and current address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r   <= {(ADDR_W+1){1'b0}};
            count_r <= {(ADDR_W+1){1'b0}};
            addr_r  <= BASE_ADDR;
        end else if (load_go_s) begin
            len_r   <= len;
            count_r <= {(ADDR_W+1){1'b0}};
            addr_r  <= BASE_ADDR;
        end else if ((state_r == ST_WRITE) && !abort) begin
            count_r <= count_inc_s;
            if (!last_word_s) begin
                // Wraps modulo 2^ADDR_W by design.
                addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                addr_r <= addr_r;
            end
        end else begin
            len_r   <= len_r;
            count_r <= count_r;
            addr_r  <= addr_r;
        end
    end

    // Byte lane assembly of the low three bytes; the fourth comes straight
    // from byte_data when the word completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_r <= 2'd0;
            word_r     <= 24'h000000;
        end else if (load_go_s) begin
            byte_idx_r <= 2'd0;
            word_r     <= 24'h000000;
        end else if (xfer_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            case (byte_idx_r)
                2'd0:    word_r[7:0]   <= byte_data;
                2'd1:    word_r[15:8]  <= byte_data;
                2'd2:    word_r[23:16] <= byte_data;
                default: word_r        <= word_r;
            endcase
        end else begin
            byte_idx_r <= byte_idx_r;
            word_r     <= word_r;
        end
    end

    // Write data register: captured on word completion, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata_r <= 32'h00000000;
        end else if (last_byte_s && !opcode_bad_s) begin
            wdata_r <= full_word_s;
        end else begin
            wdata_r <= wdata_r;
        end
    end

    // Abort suppresses the write strobe and done pulse in its own cycle.
    assign byte_ready = byte_ready_s;
    assign imem_we    = we_r && !abort;
    assign imem_addr  = addr_r;
    assign imem_wdata = wdata_r;
    assign cpu_hold   = hold_r;
    assign busy       = busy_r;
    assign done       = done_r && !abort;
    assign error      = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: stream loads, gapped stream, length
// corner cases, abort, opcode check and mid-load reset.
module tb_imem_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              abort;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    int checks   = 0;
    int errors   = 0;
    int wr_n     = 0;
    int done_cnt = 0;
    int hold_bad = 0;
    int gap_bad  = 0;
    logic [ADDR_W-1:0] wr_addr [0:15];
    logic [31:0]       wr_data [0:15];

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(10'd0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .abort      (abort),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor: logs imem writes, counts done pulses, tracks cpu_hold.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_n < 16) begin
                wr_addr[wr_n] = imem_addr;
                wr_data[wr_n] = imem_wdata;
            end
            wr_n = wr_n + 1;
        end
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (cpu_hold !== busy) hold_bad = hold_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        wr_n     = 0;
        done_cnt = 0;
        gap_bad  = 0;
        for (int i = 0; i < 16; i++) begin
            wr_addr[i] = 'x;
            wr_data[i] = 'x;
        end
    endtask

    task automatic do_start(input logic [ADDR_W:0] l);
        start = 1'b1;
        len   = l;
        tick(1);
        start = 1'b0;
    endtask

    // Idle for 'gap' cycles (byte_ready must stay high outside WRITE), then
    // offer one byte and wait, bounded, until it is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (imem_we !== 1'b1 && byte_ready !== 1'b1) gap_bad = gap_bad + 1;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        chk("xfer_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        logic [31:0] t;
        t = w;
        send_byte(t[7:0], gap);
        send_byte(t[15:8], gap);
        send_byte(t[23:16], gap);
        send_byte(t[31:24], gap);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        len        = '0;
        abort      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        clear_mon();
        tick(3);

        // Reset state
        chk("rst_flags", {26'd0, byte_ready, imem_we, cpu_hold, busy, done, error}, 32'd0);
        chk("rst_addr", {22'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'h00000000);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // Two-word load, no gaps
        clear_mon();
        do_start(11'd2);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_hold", {31'd0, cpu_hold}, 32'd1);
        send_word(32'h00500093, 0);
        send_word(32'h00A00113, 0);
        tick(4);
        chk("t1_wr_n", wr_n, 32'd2);
        chk("t1_addr0", {22'd0, wr_addr[0]}, 32'd0);
        chk("t1_data0", wr_data[0], 32'h00500093);
        chk("t1_addr1", {22'd0, wr_addr[1]}, 32'd1);
        chk("t1_data1", wr_data[1], 32'h00A00113);
        chk("t1_done", done_cnt, 32'd1);
        chk("t1_error", {31'd0, error}, 32'd0);
        chk("t1_idle", {31'd0, busy}, 32'd0);

        // Same load with 3-cycle gaps between bytes
        clear_mon();
        do_start(11'd2);
        send_word(32'h00500093, 3);
        send_word(32'h00A00113, 3);
        tick(4);
        chk("t2_wr_n", wr_n, 32'd2);
        chk("t2_data0", wr_data[0], 32'h00500093);
        chk("t2_addr1", {22'd0, wr_addr[1]}, 32'd1);
        chk("t2_data1", wr_data[1], 32'h00A00113);
        chk("t2_gap_ready", gap_bad, 32'd0);
        chk("t2_done", done_cnt, 32'd1);

        // len = 0: done next cycle, no writes
        clear_mon();
        do_start(11'd0);
        chk("t3_done_pulse", {31'd0, done}, 32'd1);
        tick(1);
        chk("t3_done_clear", {31'd0, done}, 32'd0);
        chk("t3_idle", {31'd0, busy}, 32'd0);

        // len = 2^ADDR_W + 1: error, stays idle
        do_start(11'd1025);
        chk("t3_over_err", {31'd0, error}, 32'd1);
        chk("t3_over_busy", {31'd0, busy}, 32'd0);
        tick(2);
        chk("t3_over_busy2", {31'd0, busy}, 32'd0);
        chk("t3_no_writes", wr_n, 32'd0);

        // start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        len   = 11'd1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        chk("t3_abort_wins", {31'd0, busy}, 32'd0);

        // Abort after 2 bytes of word 1 in a 3-word load
        clear_mon();
        do_start(11'd3);
        chk("t4_err_cleared", {31'd0, error}, 32'd0);
        send_word(32'h00000513, 0);
        send_byte(8'h93, 0);
        send_byte(8'h05, 0);
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        abort      = 1'b1;
        #1;
        chk("t4_ready_abort", {31'd0, byte_ready}, 32'd0);
        tick(1);
        abort      = 1'b0;
        byte_valid = 1'b0;
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_error", {31'd0, error}, 32'd1);
        tick(3);
        chk("t4_wr_n", wr_n, 32'd1);
        chk("t4_addr0", {22'd0, wr_addr[0]}, 32'd0);
        chk("t4_data0", wr_data[0], 32'h00000513);
        chk("t4_no_done", done_cnt, 32'd0);

        // Next start clears error and loads from BASE_ADDR
        clear_mon();
        do_start(11'd1);
        chk("t4_restart_err", {31'd0, error}, 32'd0);
        send_word(32'h00500093, 0);
        tick(3);
        chk("t4_re_wr_n", wr_n, 32'd1);
        chk("t4_re_addr", {22'd0, wr_addr[0]}, 32'd0);
        chk("t4_re_data", wr_data[0], 32'h00500093);
        chk("t4_re_done", done_cnt, 32'd1);

        // JAL word: rejected only when the opcode check is built in
        clear_mon();
        do_start(11'd1);
        send_word(32'h0000006F, 0);
        tick(3);
`ifdef LOADER_OPCODE_CHECK_EN
        chk("t5_wr_n", wr_n, 32'd0);
        chk("t5_error", {31'd0, error}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", done_cnt, 32'd0);
`else
        chk("t5_wr_n", wr_n, 32'd1);
        chk("t5_data", wr_data[0], 32'h0000006F);
        chk("t5_error", {31'd0, error}, 32'd0);
        chk("t5_done", done_cnt, 32'd1);
`endif

        // Reset mid-RECV after 3 bytes
        clear_mon();
        do_start(11'd2);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_flags", {26'd0, byte_ready, imem_we, cpu_hold, busy, done, error}, 32'd0);
        chk("t6_rst_addr", {22'd0, imem_addr}, 32'd0);
        chk("t6_rst_wdata", imem_wdata, 32'h00000000);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        clear_mon();
        do_start(11'd1);
        send_word(32'h00500093, 0);
        tick(3);
        chk("t6_wr_n", wr_n, 32'd1);
        chk("t6_addr", {22'd0, wr_addr[0]}, 32'd0);
        chk("t6_data", wr_data[0], 32'h00500093);
        chk("t6_done", done_cnt, 32'd1);

        chk("hold_eq_busy", hold_bad, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
